// File: rtl/tea_decrypt.sv
// ---------------------------------------------------------------------------
// tea_decrypt
//   Iterative TEA decryption core (32 rounds, delta 32'h9E3779B9).
//   A ciphertext block and its 128-bit key are captured on an in_valid/in_ready
//   handshake. The rounds then run in reverse, one per clock. The plaintext is
//   presented on a held out_valid/out_ready output.
//
//   Build option: TEA_DEC_UNROLL2_EN
//     defined   : two rounds chained per clock, 16 clocks of RUN
//     undefined : one round per clock, 32 clocks of RUN
//   Both builds produce bit-identical results.
//
// Ports
//   clk               in   1   system clock, rising edge
//   reset_n           in   1   asynchronous active-low reset
//   in_valid          in   1   ciphertext/key present
//   in_ready          out  1   core can accept a block (IDLE only)
//   v1, v2            in   32  ciphertext words 0/1
//   key1..key4        in   32  key words k0..k3
//   out_valid         out  1   plaintext valid, held until accepted
//   out_ready         in   1   downstream accepts plaintext
//   v1_out, v2_out    out  32  plaintext words 0/1 (keep last value after transfer)
//   busy              out  1   high in RUN or DONE
// ---------------------------------------------------------------------------
module tea_decrypt (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic [31:0] key1,
    input  logic [31:0] key2,
    input  logic [31:0] key3,
    input  logic [31:0] key4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] v1_out,
    output logic [31:0] v2_out,
    output logic        busy
);

    localparam logic [31:0] DELTA    = 32'h9E3779B9;
    localparam logic [31:0] SUM_INIT = 32'hC6EF3720;  // delta*32 mod 2^32

`ifdef TEA_DEC_UNROLL2_EN
    localparam logic [4:0]  CNT_STEP = 5'd2;
    localparam logic [4:0]  CNT_LAST = 5'd30;          // rounds 30 and 31 in the final clock
    localparam logic [31:0] SUM_STEP = 32'h3C6EF372;   // 2*delta mod 2^32
`else
    localparam logic [4:0]  CNT_STEP = 5'd1;
    localparam logic [4:0]  CNT_LAST = 5'd31;
    localparam logic [31:0] SUM_STEP = DELTA;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] y_q, y_d, z_q, z_d, sum_q, sum_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [31:0] v1_out_q, v1_out_d, v2_out_q, v2_out_d;

    // One inverse round; z is updated first and the new z feeds the y update.
    function automatic logic [63:0] dec_round(
        input logic [31:0] y, input logic [31:0] z, input logic [31:0] sum,
        input logic [31:0] k0, input logic [31:0] k1,
        input logic [31:0] k2, input logic [31:0] k3);
        logic [31:0] zn, yn;
        zn = z - (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
        yn = y - (((zn << 4) + k0) ^ (zn + sum) ^ ((zn >> 5) + k1));
        return {yn, zn};
    endfunction

    logic [63:0] step_yz;

`ifdef TEA_DEC_UNROLL2_EN
    logic [63:0] first_yz;
    assign first_yz = dec_round(y_q, z_q, sum_q, k0_q, k1_q, k2_q, k3_q);
    assign step_yz  = dec_round(first_yz[63:32], first_yz[31:0], sum_q - DELTA,
                                k0_q, k1_q, k2_q, k3_q);
`else
    assign step_yz  = dec_round(y_q, z_q, sum_q, k0_q, k1_q, k2_q, k3_q);
`endif

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        z_d      = z_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        k0_d     = k0_q;
        k1_d     = k1_q;
        k2_d     = k2_q;
        k3_d     = k3_q;
        v1_out_d = v1_out_q;
        v2_out_d = v2_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d     = v1;
                    z_d     = v2;
                    k0_d    = key1;
                    k1_d    = key2;
                    k2_d    = key3;
                    k3_d    = key4;
                    sum_d   = SUM_INIT;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                y_d   = step_yz[63:32];
                z_d   = step_yz[31:0];
                sum_d = sum_q - SUM_STEP;
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    // Result goes into dedicated output registers so it
                    // survives the next capture overwriting y/z.
                    v1_out_d = step_yz[63:32];
                    v2_out_d = step_yz[31:0];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            y_q      <= '0;
            z_q      <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            k0_q     <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            k3_q     <= '0;
            v1_out_q <= '0;
            v2_out_q <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            z_q      <= z_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            k0_q     <= k0_d;
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            k3_q     <= k3_d;
            v1_out_q <= v1_out_d;
            v2_out_q <= v2_out_d;
        end
    end

    // All handshake outputs decode from state only.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign v1_out    = v1_out_q;
    assign v2_out    = v2_out_q;

    // Having undone every delta step, the running sum must be back at zero.
    sum_zero_at_done: assert property (
        @(posedge clk) disable iff (!reset_n) (state_q == DONE) |-> (sum_q == 32'd0));

endmodule

// File: tb/tb_tea_decrypt.sv
module tb_tea_decrypt;

    localparam logic [31:0] DELTA = 32'h9E3779B9;
`ifdef TEA_DEC_UNROLL2_EN
    localparam int LAT    = 16;
`else
    localparam int LAT    = 32;
`endif
    localparam int PERIOD = LAT + 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] v1 = '0, v2 = '0;
    logic [31:0] key1 = '0, key2 = '0, key3 = '0, key4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] v1_out, v2_out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    tea_decrypt dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .v1(v1), .v2(v2), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .out_valid(out_valid), .out_ready(out_ready),
        .v1_out(v1_out), .v2_out(v2_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Directed plaintext/key table
    logic [31:0] pt0_tab [6] = '{32'h00000000, 32'h01234567, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h80000000, 32'h13579BDF};
    logic [31:0] pt1_tab [6] = '{32'h00000001, 32'h89ABCDEF, 32'hFFFFFFFF, 32'hCAFEBABE, 32'h00000001, 32'h2468ACE0};
    logic [31:0] k0_tab  [6] = '{32'h00000000, 32'h00112233, 32'hFFFFFFFF, 32'h01020304, 32'hA5A5A5A5, 32'h0F1E2D3C};
    logic [31:0] k1_tab  [6] = '{32'h00000000, 32'h44556677, 32'hFFFFFFFF, 32'h05060708, 32'h5A5A5A5A, 32'h4B5A6978};
    logic [31:0] k2_tab  [6] = '{32'h00000000, 32'h8899AABB, 32'hFFFFFFFF, 32'h090A0B0C, 32'h00000000, 32'h8796A5B4};
    logic [31:0] k3_tab  [6] = '{32'h00000001, 32'hCCDDEEFF, 32'hFFFFFFFF, 32'h0D0E0F10, 32'hFFFFFFFF, 32'hC3D2E1F0};

    logic        mon_en = 1'b0;
    logic [63:0] res_q [$];

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) res_q.push_back({v1_out, v2_out});
    end

    // Reference TEA encryption (forward direction)
    function automatic logic [63:0] tea_enc(input logic [31:0] p0, input logic [31:0] p1,
                                            input logic [31:0] k0, input logic [31:0] k1,
                                            input logic [31:0] k2, input logic [31:0] k3);
        logic [31:0] a, b, s;
        a = p0; b = p1; s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            s = s + DELTA;
            a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
            b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
        end
        return {a, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_block(input logic [63:0] ct, input logic [31:0] k0, input logic [31:0] k1,
                               input logic [31:0] k2, input logic [31:0] k3);
        @(negedge clk);
        check("in_ready_before_capture", {63'd0, in_ready}, 64'd1);
        v1 = ct[63:32]; v2 = ct[31:0];
        key1 = k0; key2 = k1; key3 = k2; key4 = k3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 200);
        check("done_reached", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_xfer", {63'd0, out_valid}, 64'd0);
        check("in_ready_after_xfer", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_block(input string tag, input logic [63:0] ct, input logic [63:0] exp,
                             input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [31:0] k3);
        int cyc;
        start_block(ct, k0, k1, k2, k3);
        wait_done(cyc);
        $display("blk %s: ct=%h out=%h exp=%h cycles=%0d", tag, ct, {v1_out, v2_out}, exp, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        check({tag, "_data"}, {v1_out, v2_out}, exp);
        handshake();
    endtask

    initial begin
        logic [63:0] ct, pt, held;
        int          cyc, w;
        logic        bad_flag;
        int          cap [5];

        // Reset state
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_outputs", {v1_out, v2_out}, 64'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Published zero-key / zero-plaintext vector
        run_block("zero_vec", {32'h41EA3A0A, 32'h94BAA940}, 64'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Directed round trips
        for (int i = 0; i < 6; i++) begin
            pt = {pt0_tab[i], pt1_tab[i]};
            ct = tea_enc(pt0_tab[i], pt1_tab[i], k0_tab[i], k1_tab[i], k2_tab[i], k3_tab[i]);
            run_block($sformatf("rt%0d", i), ct, pt, k0_tab[i], k1_tab[i], k2_tab[i], k3_tab[i]);
        end

        // Backpressure: DONE held 10 cycles, second in_valid ignored
        pt = {32'h0BADF00D, 32'h600DCAFE};
        ct = tea_enc(pt[63:32], pt[31:0], k0_tab[1], k1_tab[1], k2_tab[1], k3_tab[1]);
        start_block(ct, k0_tab[1], k1_tab[1], k2_tab[1], k3_tab[1]);
        wait_done(cyc);
        held = {v1_out, v2_out};
        bad_flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            v1 = 32'h11111111 * i; v2 = ~v1;
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || !busy || {v1_out, v2_out} !== held) bad_flag = 1'b1;
        end
        $display("blk backpressure: out=%h exp=%h", held, pt);
        check("bp_data", held, pt);
        check("bp_stable", {63'd0, bad_flag}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        check("bp_retain_outputs", {v1_out, v2_out}, pt);
        repeat (3) @(posedge clk);
        #1;
        check("bp_second_ignored_busy", {63'd0, busy}, 64'd0);

        // Input perturbation during RUN
        pt = {32'h76543210, 32'hFEDCBA98};
        ct = tea_enc(pt[63:32], pt[31:0], k0_tab[3], k1_tab[3], k2_tab[3], k3_tab[3]);
        start_block(ct, k0_tab[3], k1_tab[3], k2_tab[3], k3_tab[3]);
        for (int i = 0; i < LAT - 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            v1 = $urandom; v2 = $urandom;
            key1 = $urandom; key2 = $urandom; key3 = $urandom; key4 = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(cyc);
        $display("blk perturb: out=%h exp=%h", {v1_out, v2_out}, pt);
        check("perturb_data", {v1_out, v2_out}, pt);
        handshake();

        // Mid-operation asynchronous reset at round 15
        pt = {32'hAAAA5555, 32'h3C3CC3C3};
        ct = tea_enc(pt[63:32], pt[31:0], k0_tab[5], k1_tab[5], k2_tab[5], k3_tab[5]);
        start_block(ct, k0_tab[5], k1_tab[5], k2_tab[5], k3_tab[5]);
        repeat (15) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        $display("blk midreset: out_valid=%0b out=%h busy=%0b", out_valid, {v1_out, v2_out}, busy);
        check("mr_out_valid", {63'd0, out_valid}, 64'd0);
        check("mr_outputs_zero", {v1_out, v2_out}, 64'd0);
        check("mr_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad_flag = 1'b0;
        repeat (LAT + 8) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) bad_flag = 1'b1;
        end
        check("mr_no_phantom_valid", {63'd0, bad_flag}, 64'd0);
        run_block("post_reset", ct, pt, k0_tab[5], k1_tab[5], k2_tab[5], k3_tab[5]);

        // Back-to-back: in_valid and out_ready held high for 5 blocks
        res_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            ct = tea_enc(pt0_tab[b], pt1_tab[b], k0_tab[2], k1_tab[2], k2_tab[2], k3_tab[2]);
            v1 = ct[63:32]; v2 = ct[31:0];
            key1 = k0_tab[2]; key2 = k1_tab[2]; key3 = k2_tab[2]; key4 = k3_tab[2];
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            cap[b] = cyc_cnt;
            @(negedge clk);
        end
        in_valid = 1'b0;
        w = 0;
        while (res_q.size() < 5 && w < 200) begin
            @(negedge clk);
            w++;
        end
        out_ready = 1'b0;
        mon_en = 1'b0;
        check("b2b_count", 64'(res_q.size()), 64'd5);
        for (int b = 1; b < 5; b++) begin
            $display("blk b2b%0d: capture period=%0d", b, cap[b] - cap[b-1]);
            check($sformatf("b2b_period%0d", b), 64'(cap[b] - cap[b-1]), 64'(PERIOD));
        end
        for (int b = 0; b < 5; b++) begin
            if (b < res_q.size()) begin
                $display("blk b2b%0d: out=%h exp=%h", b, res_q[b], {pt0_tab[b], pt1_tab[b]});
                check($sformatf("b2b_data%0d", b), res_q[b], {pt0_tab[b], pt1_tab[b]});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tea_decrypt.md
# tea_decrypt

Iterative TEA (Tiny Encryption Algorithm) decryption core; the inverse of the team's TEA encryption block.
- Accepts one 64-bit ciphertext block (two 32-bit words) plus a 128-bit key over a valid/ready handshake.
- Runs the 32 standard TEA rounds in reverse, one round per clock by default.
- Presents the 64-bit plaintext on a held valid/ready output.
- Sits on the receive side of the link, downstream of whatever carries ciphertext from the encryptor.

## Interface
- No parameters; round count fixed at 32, delta fixed at 32'h9E3779B9.
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ciphertext/key present
- in_ready  output  1  core can accept a block (high only in IDLE)
- v1  input  32  ciphertext word 0
- v2  input  32  ciphertext word 1
- key1, key2, key3, key4  input  32 each  key words k0..k3
- out_valid  output  1  plaintext valid, held until accepted
- out_ready  input  1  downstream accepts plaintext
- v1_out  output  32  plaintext word 0
- v2_out  output  32  plaintext word 1
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch v1/v2 into working regs y/z;
  - latch all four key words;
  - sum <= 32'hC6EF3720 (delta*32 mod 2^32);
  - round counter <= 0;
  - go to RUN.
- Inputs are sampled only at capture; later input changes are ignored.
- RUN, per round, with all arithmetic mod 2^32 and logical shifts:
  - z' = z - (((y<<4)+k2) ^ (y+sum) ^ ((y>>5)+k3))
  - y' = y - (((z'<<4)+k0) ^ (z'+sum) ^ ((z'>>5)+k1)); uses the updated z' within the same cycle.
  - sum <= sum - delta.
  - Counter increments; after the round with counter==31, go to DONE.
  - sum ends at 0 (assertion target).
- DONE:
  - v1_out=y, v2_out=z, out_valid=1.
  - Outputs and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE with out_valid=0; v1_out/v2_out retain their last value.
- in_valid is ignored outside IDLE; no queueing, no overflow.
- Reset (any time, including mid-RUN or in DONE):
  - state IDLE, out_valid=0, busy=0;
  - v1_out=v2_out=0, y=z=sum=counter=0, keys=0;
  - in_ready=1 once reset_n deasserts.
  - An aborted block never produces out_valid.

## Timing
- Capture edge E0. Round k executes on edge E(k+1).
- out_valid rises after edge E32: 32 cycles capture-to-valid (16 with the unroll macro).
- out_ready high while out_valid is high: transfer on that edge, in_ready is high the next cycle.
- Minimum block period: 34 cycles (capture + 32 rounds + handshake cycle).
- in_ready and busy decode from state only; no combinational path from in_valid or out_ready to any output.

## Configuration
- TEA_DEC_UNROLL2_EN:
  - Defined: two rounds are chained combinationally per clock, sum decrements by 2*delta per clock, and RUN lasts 16 cycles. Capture-to-valid is 16 cycles and minimum block period 18.
  - Undefined: one round per clock as above.
- Results are bit-identical in both builds.

## Test plan
- Reset then zero vector: key=0, v1=32'h41EA3A0A, v2=32'h94BAA940 -> v1_out=0, v2_out=0, out_valid exactly 32 cycles after capture (16 if unrolled).
- Round trip: 100 random key/plaintext pairs, encrypted by the C reference model and fed in -> output equals original plaintext; sum==0 at DONE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs and out_valid stable, in_ready=0, second in_valid ignored; release -> in_ready=1 the following cycle.
- Input perturbation: change v1/v2/keys every cycle during RUN -> result matches the values latched at capture.
- Mid-operation reset: assert reset_n=0 at round 15 -> out_valid=0, outputs 0 immediately (asynchronous); a following block decrypts correctly.
- Back-to-back: in_valid and out_ready held high for 5 blocks -> each block accepted every 34 cycles, all 5 results correct and in order.
